// File: rtl/regfile_pkg.sv
// Shared constants and types for the register file write arbiter.
package regfile_pkg;
  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 16;
  localparam int ADDR_W   = $clog2(NUM_REGS);

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  typedef enum logic {INIT, RUN} arb_state_t;
  typedef enum logic {PTR_A, PTR_B} arb_ptr_t;
endpackage

// File: rtl/regfile_write_arbiter_decoder.sv
// Enable-gated binary to one-hot decoder used for the write and read enable vectors.
module onehot_decoder
  import regfile_pkg::*;
#(
  parameter int IN_W  = ADDR_W,
  parameter int OUT_W = NUM_REGS
) (
  input  logic             en,
  input  logic [IN_W-1:0]  addr,
  output logic [OUT_W-1:0] onehot
);

  genvar gi;
  generate
    for (gi = 0; gi < OUT_W; gi++) begin : g_bit
      assign onehot[gi] = en && (addr == IN_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin write arbiter, zero-init sequencer and read decoder for a 16x16 register file.
// Optional same-cycle write forwarding outputs are built when RF_WRITE_FORWARD_EN is defined.
module regfile_write_arbiter
  import regfile_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                a_valid,
  input  logic [ADDR_W-1:0]   a_addr,
  input  logic [DATA_W-1:0]   a_data,
  output logic                a_ready,
  input  logic                b_valid,
  input  logic [ADDR_W-1:0]   b_addr,
  input  logic [DATA_W-1:0]   b_data,
  output logic                b_ready,
  input  logic [ADDR_W-1:0]   rd_addr1,
  input  logic [ADDR_W-1:0]   rd_addr2,
  output logic [NUM_REGS-1:0] wr_en,
  output logic [DATA_W-1:0]   wr_data,
  output logic [NUM_REGS-1:0] rd_en1,
  output logic [NUM_REGS-1:0] rd_en2,
  output logic                init_done
`ifdef RF_WRITE_FORWARD_EN
  ,
  output logic                fwd1,
  output logic                fwd2,
  output logic [DATA_W-1:0]   fwd_data
`endif
);

  arb_state_t state_q, state_d;
  arb_ptr_t   ptr_q, ptr_d;
  reg_addr_t  idx_q, idx_d;
  logic       init_done_q, init_done_d;
  logic       stg_we_q, stg_we_d;
  reg_addr_t  stg_addr_q, stg_addr_d;
  reg_data_t  stg_data_q, stg_data_d;
  logic       grant_a, grant_b;
  logic       run;

  assign run = (state_q == RUN);

  always_comb begin
    grant_a     = 1'b0;
    grant_b     = 1'b0;
    state_d     = state_q;
    ptr_d       = ptr_q;
    idx_d       = idx_q;
    init_done_d = init_done_q;
    stg_we_d    = 1'b0;
    stg_addr_d  = stg_addr_q;
    stg_data_d  = stg_data_q;

    if (state_q == INIT) begin
      // The write stage doubles as the init writer, so every init slot goes through wr_en.
      stg_we_d   = 1'b1;
      stg_addr_d = idx_q;
      stg_data_d = '0;
      idx_d      = reg_addr_t'(idx_q + 1'b1);
      if (idx_q == reg_addr_t'(NUM_REGS - 1)) begin
        state_d = RUN;
      end
    end else begin
      init_done_d = 1'b1;
      grant_a     = a_valid && (!b_valid || ptr_q == PTR_A);
      grant_b     = b_valid && !grant_a;
      if (grant_a) begin
        ptr_d      = PTR_B;
        stg_addr_d = a_addr;
        stg_data_d = a_data;
        stg_we_d   = (a_addr != '0);
      end else if (grant_b) begin
        ptr_d      = PTR_A;
        stg_addr_d = b_addr;
        stg_data_d = b_data;
        stg_we_d   = (b_addr != '0);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= INIT;
      ptr_q       <= PTR_A;
      idx_q       <= '0;
      init_done_q <= 1'b0;
      stg_we_q    <= 1'b0;
      stg_addr_q  <= '0;
      stg_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      idx_q       <= idx_d;
      init_done_q <= init_done_d;
      stg_we_q    <= stg_we_d;
      stg_addr_q  <= stg_addr_d;
      stg_data_q  <= stg_data_d;
    end
  end

  assign a_ready   = grant_a;
  assign b_ready   = grant_b;
  assign wr_data   = stg_data_q;
  assign init_done = init_done_q;

  onehot_decoder #(.IN_W(ADDR_W), .OUT_W(NUM_REGS)) u_wr_dec (
    .en    (stg_we_q),
    .addr  (stg_addr_q),
    .onehot(wr_en)
  );

  onehot_decoder #(.IN_W(ADDR_W), .OUT_W(NUM_REGS)) u_rd1_dec (
    .en    (run),
    .addr  (rd_addr1),
    .onehot(rd_en1)
  );

  onehot_decoder #(.IN_W(ADDR_W), .OUT_W(NUM_REGS)) u_rd2_dec (
    .en    (run),
    .addr  (rd_addr2),
    .onehot(rd_en2)
  );

`ifdef RF_WRITE_FORWARD_EN
  assign fwd1     = stg_we_q && (stg_addr_q != '0) && (rd_addr1 == stg_addr_q);
  assign fwd2     = stg_we_q && (stg_addr_q != '0) && (rd_addr2 == stg_addr_q);
  assign fwd_data = stg_data_q;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed testbench for regfile_write_arbiter with a behavioural register file on the write port.
module tb_regfile_write_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid;
  logic [3:0]  a_addr, b_addr, rd_addr1, rd_addr2;
  logic [15:0] a_data, b_data;
  logic        a_ready, b_ready, init_done;
  logic [15:0] wr_en, wr_data, rd_en1, rd_en2;
`ifdef RF_WRITE_FORWARD_EN
  logic        fwd1, fwd2;
  logic [15:0] fwd_data;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regfile_write_arbiter dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .wr_en(wr_en), .wr_data(wr_data), .rd_en1(rd_en1), .rd_en2(rd_en2),
    .init_done(init_done)
`ifdef RF_WRITE_FORWARD_EN
    , .fwd1(fwd1), .fwd2(fwd2), .fwd_data(fwd_data)
`endif
  );

  // Behavioural bitcell array and bitlines
  logic [15:0] rf [16];
  logic [15:0] bl1, bl2;
  always @(posedge clk) begin
    for (int i = 0; i < 16; i++) if (wr_en[i]) rf[i] <= wr_data;
  end
  always_comb begin
    bl1 = '0;
    bl2 = '0;
    for (int i = 0; i < 16; i++) begin
      if (rd_en1[i]) bl1 = bl1 | rf[i];
      if (rd_en2[i]) bl2 = bl2 | rf[i];
    end
  end

  task automatic test_init();
    logic [15:0] exp_oh;
    rst = 1'b1;
    a_valid = 1'b0; b_valid = 1'b0;
    a_addr = 4'd0; b_addr = 4'd0; a_data = '0; b_data = '0;
    rd_addr1 = 4'd3; rd_addr2 = 4'd3;
    @(negedge clk); #1;
    total++; if (wr_en !== 16'h0000 || wr_data !== 16'h0000) begin bad++; $display("FAIL reset_wr got wr_en=%h wr_data=%h exp 0000/0000", wr_en, wr_data); end
    total++; if (init_done !== 1'b0 || rd_en1 !== 16'h0000) begin bad++; $display("FAIL reset_misc got init_done=%b rd_en1=%h exp 0/0000", init_done, rd_en1); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      a_valid = 1'b1; b_valid = 1'b1;
      #1;
      total++; if (a_ready !== 1'b0 || b_ready !== 1'b0 || rd_en2 !== 16'h0000) begin bad++; $display("FAIL init_ready[%0d] got a_ready=%b b_ready=%b rd_en2=%h exp 0/0/0000", i, a_ready, b_ready, rd_en2); end
      @(negedge clk);
      exp_oh = 16'd1 << i;
      total++; if (wr_en !== exp_oh || wr_data !== 16'h0000) begin bad++; $display("FAIL init_wr[%0d] got wr_en=%h wr_data=%h exp %h/0000", i, wr_en, wr_data, exp_oh); end
      total++; if (init_done !== 1'b0) begin bad++; $display("FAIL init_done_early[%0d] got %b exp 0", i, init_done); end
    end
    a_valid = 1'b0; b_valid = 1'b0;
    @(negedge clk);
    total++; if (init_done !== 1'b1 || wr_en !== 16'h0000) begin bad++; $display("FAIL init_done_rise got init_done=%b wr_en=%h exp 1/0000", init_done, wr_en); end
    $display("init sequence checked");
  endtask

  task automatic test_single();
    @(negedge clk);
    a_valid = 1'b1; a_addr = 4'd3; a_data = 16'hBEEF;
    #1;
    total++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin bad++; $display("FAIL single_ready got a=%b b=%b exp 1/0", a_ready, b_ready); end
    @(negedge clk);
    a_valid = 1'b0;
    total++; if (wr_en !== 16'h0008 || wr_data !== 16'hBEEF) begin bad++; $display("FAIL single_wr got wr_en=%h wr_data=%h exp 0008/beef", wr_en, wr_data); end
    @(negedge clk);
    total++; if (wr_en !== 16'h0000) begin bad++; $display("FAIL single_nowr got wr_en=%h exp 0000", wr_en); end
    rd_addr1 = 4'd3;
    #1;
    total++; if (rd_en1 !== 16'h0008 || bl1 !== 16'hBEEF) begin bad++; $display("FAIL single_rd got rd_en1=%h bl1=%h exp 0008/beef", rd_en1, bl1); end
    $display("single write reg3=beef checked");
  endtask

  task automatic test_reg0();
    @(negedge clk);
    b_valid = 1'b1; b_addr = 4'd0; b_data = 16'h1234;
    #1;
    total++; if (b_ready !== 1'b1 || a_ready !== 1'b0) begin bad++; $display("FAIL reg0_ready got b=%b a=%b exp 1/0", b_ready, a_ready); end
    @(negedge clk);
    b_valid = 1'b0;
    total++; if (wr_en !== 16'h0000) begin bad++; $display("FAIL reg0_wr got wr_en=%h exp 0000", wr_en); end
    @(negedge clk);
    rd_addr2 = 4'd0;
    #1;
    total++; if (rd_en2 !== 16'h0001 || bl2 !== 16'h0000) begin bad++; $display("FAIL reg0_rd got rd_en2=%h bl2=%h exp 0001/0000", rd_en2, bl2); end
    $display("write to reg0 suppressed checked");
  endtask

  task automatic test_contention();
    logic exp_a;
    @(negedge clk);
    a_valid = 1'b1; a_addr = 4'd1; a_data = 16'h1111;
    b_valid = 1'b1; b_addr = 4'd2; b_data = 16'h2222;
    for (int k = 0; k < 4; k++) begin
      exp_a = (k % 2 == 0);
      #1;
      total++; if (a_ready !== exp_a || b_ready !== !exp_a) begin bad++; $display("FAIL contend_grant[%0d] got a=%b b=%b exp %b/%b", k, a_ready, b_ready, exp_a, !exp_a); end
      @(negedge clk);
      total++; if (wr_en !== (exp_a ? 16'h0002 : 16'h0004)) begin bad++; $display("FAIL contend_wr[%0d] got wr_en=%h exp %h", k, wr_en, exp_a ? 16'h0002 : 16'h0004); end
    end
    a_valid = 1'b0; b_valid = 1'b0;
    @(negedge clk);
    rd_addr1 = 4'd1; rd_addr2 = 4'd2;
    #1;
    total++; if (bl1 !== 16'h1111 || bl2 !== 16'h2222) begin bad++; $display("FAIL contend_rd got bl1=%h bl2=%h exp 1111/2222", bl1, bl2); end
    rd_addr1 = 4'd2;
    #1;
    total++; if (rd_en1 !== 16'h0004 || rd_en2 !== 16'h0004) begin bad++; $display("FAIL same_rd_addr got rd_en1=%h rd_en2=%h exp 0004/0004", rd_en1, rd_en2); end
    $display("contention A,B,A,B checked");
  endtask

  task automatic test_same_addr();
    @(negedge clk);
    a_valid = 1'b1; a_addr = 4'd9; a_data = 16'hAAAA;
    b_valid = 1'b1; b_addr = 4'd9; b_data = 16'hBBBB;
    #1;
    total++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin bad++; $display("FAIL same_first got a=%b b=%b exp 1/0", a_ready, b_ready); end
    @(negedge clk);
    a_valid = 1'b0;
    #1;
    total++; if (b_ready !== 1'b1 || wr_en !== 16'h0200 || wr_data !== 16'hAAAA) begin bad++; $display("FAIL same_second got b=%b wr_en=%h wr_data=%h exp 1/0200/aaaa", b_ready, wr_en, wr_data); end
    @(negedge clk);
    b_valid = 1'b0;
    total++; if (wr_en !== 16'h0200 || wr_data !== 16'hBBBB) begin bad++; $display("FAIL same_wr2 got wr_en=%h wr_data=%h exp 0200/bbbb", wr_en, wr_data); end
    @(negedge clk);
    rd_addr1 = 4'd9;
    #1;
    total++; if (bl1 !== 16'hBBBB) begin bad++; $display("FAIL same_rd got %h exp bbbb", bl1); end
    $display("same-address later write wins checked");
  endtask

  task automatic test_rdw();
    @(negedge clk);
    a_valid = 1'b1; a_addr = 4'd7; a_data = 16'hCAFE;
    @(negedge clk);
    a_valid = 1'b0;
    rd_addr1 = 4'd6; rd_addr2 = 4'd7;
    #1;
    total++; if (wr_en !== 16'h0080 || bl2 !== 16'h0000) begin bad++; $display("FAIL rdw_old got wr_en=%h bl2=%h exp 0080/0000", wr_en, bl2); end
`ifdef RF_WRITE_FORWARD_EN
    total++; if (fwd2 !== 1'b1 || fwd1 !== 1'b0 || fwd_data !== 16'hCAFE) begin bad++; $display("FAIL rdw_fwd got fwd1=%b fwd2=%b fwd_data=%h exp 0/1/cafe", fwd1, fwd2, fwd_data); end
`endif
    @(negedge clk);
    #1;
    total++; if (bl2 !== 16'hCAFE) begin bad++; $display("FAIL rdw_after got %h exp cafe", bl2); end
    $display("read during write reg7 checked");
  endtask

  task automatic test_reset_mid_write();
    @(negedge clk);
    a_valid = 1'b1; a_addr = 4'd5; a_data = 16'h00FF;
    #1;
    total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL midrst_accept got %b exp 1", a_ready); end
    #2;
    rst = 1'b1;
    #1;
    total++; if (wr_en !== 16'h0000 || a_ready !== 1'b0 || init_done !== 1'b0 || wr_data !== 16'h0000) begin bad++; $display("FAIL midrst_clear got wr_en=%h a_ready=%b init_done=%b wr_data=%h exp 0000/0/0/0000", wr_en, a_ready, init_done, wr_data); end
    @(negedge clk);
    a_valid = 1'b0;
    total++; if (wr_en !== 16'h0000) begin bad++; $display("FAIL midrst_nowr got wr_en=%h exp 0000", wr_en); end
    $display("reset mid-write checked, re-running init");
    test_init();
  endtask

  initial begin
    test_init();
    test_single();
    test_reg0();
    test_contention();
    test_same_addr();
    test_rdw();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
